// File: rtl/aes_pkg.sv
// aes_pkg: shared AES-128 key-schedule constants, Rcon table and FSM state type
package aes_pkg;
    localparam int NR    = 10;
    localparam int NK    = 4;
    localparam int KEY_W = 128;
    // Indexed by round number. Entry 0 and 11..15 are zero, so idx+1 past the last round is harmless.
    localparam logic [7:0] RCON [16] = '{
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
        8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
    };
    typedef enum logic [1:0] {IDLE, GEN, EMIT, FIN} state_t;
endpackage

// File: rtl/aes_sbox.sv
// aes_sbox: combinational AES forward S-box; i_byte in, o_byte = SubBytes(i_byte) out
module aes_sbox (
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);
    localparam logic [7:0] L_SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };
    assign o_byte = L_SBOX[i_byte];
endmodule

// File: rtl/aes_key_schedule.sv
// aes_key_schedule: sequential AES-128 key expansion, emits round keys 0..10 over valid/ready
//   clk, rst_n (async active-low); start/key request an expansion (dec too when AES_KEY_DEC_EN);
//   busy while expanding; rk_valid/rk_ready/rk/rk_idx round-key handshake; done one-cycle pulse.
//   AES_KEY_DEC_EN: adds dec input; dec=1 pre-expands into a buffer then emits keys 10 down to 0.
module aes_key_schedule
    import aes_pkg::*;
#(
    parameter int NR = aes_pkg::NR
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [KEY_W-1:0] key,
`ifdef AES_KEY_DEC_EN
    input  logic             dec,
`endif
    output logic             busy,
    output logic             rk_valid,
    input  logic             rk_ready,
    output logic [KEY_W-1:0] rk,
    output logic [3:0]       rk_idx,
    output logic             done
);
    localparam int         L_WW   = KEY_W / NK;
    localparam logic [3:0] L_LAST = 4'(NR);

    state_t           r_state, w_state_nxt;
    logic [KEY_W-1:0] r_key, w_next;
    logic [3:0]       r_idx;
    logic             r_dec, w_dec_in, w_go, w_fire, w_last;
    logic [L_WW-1:0]  w_w0, w_w1, w_w2, w_w3, w_rot, w_sub, w_t, w_n0, w_n1, w_n2, w_n3;

    assign {w_w0, w_w1, w_w2, w_w3} = r_key;
    assign w_rot = {w_w3[23:0], w_w3[31:24]};
    for (genvar b = 0; b < 4; b++) begin : g_sub
        aes_sbox u_sbox (.i_byte(w_rot[8*b +: 8]), .o_byte(w_sub[8*b +: 8]));
    end
    assign w_t    = w_sub ^ {RCON[r_idx + 4'd1], 24'h0};
    assign w_n0   = w_w0 ^ w_t;
    assign w_n1   = w_w1 ^ w_n0;
    assign w_n2   = w_w2 ^ w_n1;
    assign w_n3   = w_w3 ^ w_n2;
    assign w_next = {w_n0, w_n1, w_n2, w_n3};

    // FIN accepts start too, so expansions can run back-to-back.
    assign w_go   = start && (r_state == IDLE || r_state == FIN);
    assign w_fire = (r_state == EMIT) && rk_ready;
    assign w_last = r_dec ? (r_idx == 4'd0) : (r_idx == L_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE, FIN: w_state_nxt = w_go ? (w_dec_in ? GEN : EMIT) : IDLE;
            GEN:       w_state_nxt = (r_idx == L_LAST - 4'd1) ? EMIT : GEN;
            EMIT:      w_state_nxt = (w_fire && w_last) ? FIN : EMIT;
            default:   w_state_nxt = IDLE;
        endcase
    end

    // GEN and forward EMIT both step the key register; reverse EMIT only walks the index down.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_key <= '0;
            r_idx <= '0;
            r_dec <= 1'b0;
        end else if (w_go) begin
            r_key <= key;
            r_idx <= '0;
            r_dec <= w_dec_in;
        end else if (r_state == GEN || (w_fire && !w_last && !r_dec)) begin
            r_key <= w_next;
            r_idx <= r_idx + 4'd1;
        end else if (w_fire && !w_last) begin
            r_idx <= r_idx - 4'd1;
        end
    end

`ifdef AES_KEY_DEC_EN
    logic [KEY_W-1:0] r_buf [NR+1];
    always_ff @(posedge clk) begin
        if (w_go)                 r_buf[0] <= key;
        else if (r_state == GEN)  r_buf[r_idx + 4'd1] <= w_next;
    end
    assign w_dec_in = dec;
    assign rk       = r_dec ? r_buf[r_idx] : r_key;
`else
    assign w_dec_in = 1'b0;
    assign rk       = r_key;
`endif

    assign busy     = (r_state == GEN) || (r_state == EMIT);
    assign rk_valid = (r_state == EMIT);
    assign rk_idx   = r_idx;
    assign done     = (r_state == FIN);
endmodule

// File: doc/aes_key_schedule.md
# aes_key_schedule

Sequential AES-128 key expansion engine. Sits directly upstream of the encrypt round datapath and supplies one 128-bit round key per round. Accepts a cipher key on `start` and emits round keys 0..10 in order over a valid/ready handshake, computing each next key on the fly at one key per cycle.

## Interface
- `NR`, default 10: number of rounds. Fixed for AES-128; any other value is unsupported.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request expansion of `key`; sampled only when `busy`=0.
- `key`  in  128  cipher key; byte 0 is in [127:120].
- `busy`  out  1  high while an expansion is in progress.
- `rk_valid`  out  1  `rk` and `rk_idx` are valid.
- `rk_ready`  in  1  consumer accepts the key.
- `rk`  out  128  round key; byte order matches `key`.
- `rk_idx`  out  4  round number of `rk`, 0..10.
- `done`  out  1  one-cycle pulse after the final key is accepted.

## Operation
- States:
  - IDLE: wait for `start`.
  - EMIT: present keys.
  - FIN: `done` pulse, then return to IDLE.
- IDLE with `start`=1: latch `key` into the key register, set idx=0, go to EMIT.
- EMIT:
  - `rk_valid`=1.
  - On handshake (`rk_valid` & `rk_ready`) with idx<10, the register loads the next key and idx increments.
  - On handshake with idx=10, go to FIN.
- Next-key computation, with w0..w3 the current words and w3 the least significant:
  - t = SubWord(RotWord(w3)) ^ {Rcon[idx+1], 24'h0}.
  - w0' = w0 ^ t; w1' = w1 ^ w0'; w2' = w2 ^ w1'; w3' = w3 ^ w2'.
- Rcon[1..10] = 01, 02, 04, 08, 10, 20, 40, 80, 1B, 36.
- `rk` and `rk_idx` stay stable while `rk_valid`=1 and `rk_ready`=0.
- `start` while `busy`=1 is ignored; there is no queuing.
- `key` is ignored except in the cycle `start` is accepted.
- Reset (at any time, including mid-expansion) forces IDLE. All outputs go to 0: `busy`, `rk_valid`, `done`, `rk`=128'h0, `rk_idx`=0.

## Timing
- `start` accepted at edge T: `busy`=1, `rk_valid`=1, `rk_idx`=0 in the cycle after T.
- With `rk_ready` held high: idx k is presented in cycle T+1+k. The last handshake is in cycle T+11. `done`=1 and `busy`=0 in cycle T+12.
- `busy` covers the cycles from T+1 through the final handshake cycle.
- `done` is high for exactly one cycle. A new `start` is accepted in the `done` cycle, so it is back-to-back capable.
- Next key is computed combinationally from the key register. There is no combinational path from `rk_ready` to `rk`.

## Configuration
- `AES_KEY_DEC_EN` defined:
  - Adds input `dec` (1 bit), sampled with `start`.
  - `dec`=1 inserts state GEN after IDLE. GEN spends 10 cycles expanding all keys into an 11x128 buffer with `rk_valid`=0, then enters EMIT.
  - EMIT then presents idx 10 down to 0 from the buffer; FIN follows the handshake on idx 0.
  - `dec`=0 behaves exactly as without the macro.
  - `busy`=1 throughout GEN.
- `AES_KEY_DEC_EN` undefined: no `dec` port, no buffer, no GEN state; forward order only.

## Structure
- Shared package `aes_pkg` holds:
  - `NR`, `NK`=4, `KEY_W`=128.
  - The Rcon table.
  - The FSM state enum (IDLE, GEN, EMIT, FIN).
- Sub-module `aes_sbox`: one byte in, one byte out, combinational forward S-box. Instantiated 4 times for SubWord, and shared with the SubBytes stage.

## Test plan
- Key 2b7e151628aed2a6abf7158809cf4f3c, `rk_ready`=1:
  - idx1 = a0fafe1788542cb123a339392a6c7605.
  - idx10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
  - `done` is in cycle T+12.
- Key 000102030405060708090a0b0c0d0e0f -> idx10 = 13111d7fe3944a17f307a78b4d2b30c5.
- `rk_ready` toggled pseudo-randomly -> `rk` and `rk_idx` stable while stalled, no key skipped or duplicated, exactly 11 handshakes.
- `start` pulsed while `busy` with a different key -> ignored, sequence unchanged.
- `rst_n` low at idx 5, then release and restart -> all outputs 0 during reset, fresh sequence starts from idx 0.
- With `AES_KEY_DEC_EN`, `dec`=1 and the first key above:
  - 10 cycles with `rk_valid`=0.
  - idx 10 = d014f9a8..., then descending to idx 0 = 2b7e1516....
